// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizes and types for the integer register file
package reg_file_pkg;
  localparam int RF_ADDR_NBW = 5;
  localparam int RF_DATA_NBW = 32;
  localparam int RF_DEPTH = 2**RF_ADDR_NBW;
  typedef logic [RF_ADDR_NBW-1:0] rf_addr_t;
  typedef logic [RF_DATA_NBW-1:0] rf_data_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits, flush over reserve over writeback clear
module reg_scoreboard import reg_file_pkg::*; #(
  parameter int ADDR_NBW = RF_ADDR_NBW,
  parameter int WR_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_async_n,
  input  logic                         i_flush,
  input  logic                         i_rsv_en,
  input  logic [ADDR_NBW-1:0]          i_rsv_addr,
  input  logic [WR_PORTS-1:0]          i_wr_en,
  input  logic [WR_PORTS*ADDR_NBW-1:0] i_wr_addr,
  output logic [2**ADDR_NBW-1:0]       o_busy_vec
);
  logic [2**ADDR_NBW-1:0] busy_nxt;
  // later assignments override earlier ones, giving flush > reserve > clear; r0 forced idle
  always_comb begin
    busy_nxt = o_busy_vec;
    for (int j = 0; j < WR_PORTS; j++)
      if (i_wr_en[j]) busy_nxt[i_wr_addr[j*ADDR_NBW +: ADDR_NBW]] = 1'b0;
    if (i_rsv_en) busy_nxt[i_rsv_addr] = 1'b1;
    if (i_flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end
  // busy vector flops
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) o_busy_vec <= '0;
    else o_busy_vec <= busy_nxt;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with busy scoreboard; RF_BYPASS_EN enables write-first read forwarding
module reg_file_sb import reg_file_pkg::*; #(
  parameter int ADDR_NBW = RF_ADDR_NBW,
  parameter int DATA_NBW = RF_DATA_NBW,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_async_n,
  input  logic [RD_PORTS*ADDR_NBW-1:0] i_rd_addr,
  output logic [RD_PORTS*DATA_NBW-1:0] o_rd_dt,
  output logic [RD_PORTS-1:0]          o_rd_busy,
  input  logic [WR_PORTS-1:0]          i_wr_en,
  input  logic [WR_PORTS*ADDR_NBW-1:0] i_wr_addr,
  input  logic [WR_PORTS*DATA_NBW-1:0] i_wr_dt,
  input  logic                         i_rsv_en,
  input  logic [ADDR_NBW-1:0]          i_rsv_addr,
  input  logic                         i_flush,
  output logic [2**ADDR_NBW-1:0]       o_busy_vec
);
  localparam int DEPTH = 2**ADDR_NBW;
  logic [DATA_NBW-1:0] mem [DEPTH];
  logic [ADDR_NBW-1:0] ra;
  reg_scoreboard #(.ADDR_NBW(ADDR_NBW), .WR_PORTS(WR_PORTS)) u_sb (
    .clk(clk),
    .rst_async_n(rst_async_n),
    .i_flush(i_flush),
    .i_rsv_en(i_rsv_en),
    .i_rsv_addr(i_rsv_addr),
    .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr),
    .o_busy_vec(o_busy_vec)
  );
  // data array; higher write port lands last and wins, r0 is never written so stays zero
  always_ff @(posedge clk or negedge rst_async_n)
    if (!rst_async_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else for (int j = 0; j < WR_PORTS; j++)
      if (i_wr_en[j] && i_wr_addr[j*ADDR_NBW +: ADDR_NBW] != '0)
        mem[i_wr_addr[j*ADDR_NBW +: ADDR_NBW]] <= i_wr_dt[j*DATA_NBW +: DATA_NBW];
  // combinational read muxes, optionally forwarding same-cycle write data (suppressed in reset)
  always_comb begin
    o_rd_dt = '0;
    o_rd_busy = '0;
    ra = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      ra = i_rd_addr[k*ADDR_NBW +: ADDR_NBW];
      o_rd_dt[k*DATA_NBW +: DATA_NBW] = mem[ra];
      o_rd_busy[k] = o_busy_vec[ra];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < WR_PORTS; j++)
        if (rst_async_n && i_wr_en[j] && ra != '0 && i_wr_addr[j*ADDR_NBW +: ADDR_NBW] == ra) begin
          o_rd_dt[k*DATA_NBW +: DATA_NBW] = i_wr_dt[j*DATA_NBW +: DATA_NBW];
          o_rd_busy[k] = i_rsv_en && i_rsv_addr == ra;
        end
`endif
    end
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port integer register file with an integrated busy scoreboard.
- Configurable read and write port counts.
- Register 0 is hardwired to zero.
- Per-register busy bits are set when an instruction reserves a destination and cleared when that destination is written back.
- Sits between decode/issue (reads, reservations) and writeback (writes) in the core pipeline.

Parameters:
- ADDR_NBW, 5, register address width; depth = 2**ADDR_NBW.
- DATA_NBW, 32, register data width.
- RD_PORTS, 2, number of read ports (1..4).
- WR_PORTS, 2, number of write ports (1..2).

Ports:
- clk  in  1  clock, rising edge.
- rst_async_n  in  1  asynchronous active-low reset.
- i_rd_addr  in  RD_PORTS*ADDR_NBW  packed read addresses; port k at bits [k*ADDR_NBW +: ADDR_NBW].
- o_rd_dt  out  RD_PORTS*DATA_NBW  packed read data, combinational from i_rd_addr.
- o_rd_busy  out  RD_PORTS  busy bit of each addressed register, combinational.
- i_wr_en  in  WR_PORTS  per-port write enable.
- i_wr_addr  in  WR_PORTS*ADDR_NBW  packed write addresses.
- i_wr_dt  in  WR_PORTS*DATA_NBW  packed write data.
- i_rsv_en  in  1  reserve destination (set busy).
- i_rsv_addr  in  ADDR_NBW  register to reserve.
- i_flush  in  1  clear all busy bits (pipeline flush).
- o_busy_vec  out  2**ADDR_NBW  registered busy bits; bit 0 is always 0.

Behaviour:
- Reset (async, rst_async_n=0):
  - All data registers and all busy bits go to 0.
  - o_rd_dt = 0 and o_rd_busy = 0 for any address; o_busy_vec = 0.
  - Reset release is sampled at the next rising edge; no writes take effect while reset is asserted.
- Reads: zero latency, combinational. Address 0 always returns 0 with busy 0.
- Writes: take effect at the rising edge when i_wr_en[j]=1 and i_wr_addr[j]!=0. Writes to address 0 are dropped.
- Write conflict: if two write ports target the same nonzero address in one cycle, the highest port index wins.
- Busy bit update per register r at the rising edge, highest priority first:
  1. i_flush=1 -> busy[r]=0 for all r. A reservation in the same cycle is ignored; writes still update data.
  2. i_rsv_en=1 and i_rsv_addr==r, r!=0 -> busy[r]=1. This wins over a same-cycle write clear to r; data is still written.
  3. Any enabled write port with address r -> busy[r]=0.
  4. Otherwise busy[r] holds.
- i_rsv_en with i_rsv_addr=0 has no effect.
- A write to a non-busy register is legal: data is updated and busy stays 0.
- Unselected registers hold their value every cycle.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Write-first forwarding. When read port k matches a same-cycle enabled write address (nonzero), o_rd_dt[k] returns that write data, using the highest write index on conflict.
  - o_rd_busy[k] reads 0 for that address unless the same register is also being reserved in that cycle.
- Undefined:
  - Reads return the pre-edge stored value; written data is visible the cycle after the write.
  - o_rd_busy reflects stored busy bits only.

Decomposition:
- Package reg_file_pkg holds:
  - Default constants: RF_ADDR_NBW=5, RF_DATA_NBW=32.
  - Typedefs rf_addr_t and rf_data_t.
  - Constant RF_DEPTH.
- Sub-module reg_scoreboard: holds the busy-vector flops and the flush/reserve/clear priority logic. Inputs are i_flush, i_rsv_en, i_rsv_addr and per-port write enable/address. Output is the busy vector.
- reg_file_sb instantiates reg_scoreboard and implements the data array plus read muxes, with bypass under RF_BYPASS_EN.

Test Plan:
1. Reset mid-operation: write 0xDEADBEEF to r5, reserve r7, assert rst_async_n=0 between edges -> o_rd_dt for r5 = 0 immediately; o_busy_vec = 0.
2. Dual-write conflict: port0 writes 0x11 to r3 and port1 writes 0x22 to r3 in the same cycle -> r3 reads 0x22 next cycle. Port0 write of 0x33 to r0 -> r0 still reads 0.
3. Scoreboard lifecycle: reserve r9 -> o_busy_vec[9]=1 next cycle. Write 0xA5 to r9 -> busy[9]=0 and r9 reads 0xA5. Reserve r9 and write r9 in the same cycle -> busy[9]=1 and data = written value.
4. Flush priority: busy r2, r4 set; assert i_flush with i_rsv_en on r6 -> o_busy_vec = 0, r6 not busy.
5. Bypass: write 0x1234 to r8 while read port1 addresses r8.
   - RF_BYPASS_EN defined -> o_rd_dt[1]=0x1234 in the same cycle.
   - Undefined -> old value in the same cycle, 0x1234 next cycle.
6. Multi-port reads (RD_PORTS=4): r1..r4 = 1,2,3,4; read addresses {4,0,2,4} -> o_rd_dt = {4,0,2,4} combinationally, with busy bits matching o_busy_vec.
